// File: rtl/moonbase_bus_bridge_if.sv
// rtl/moonbase_bus_bridge_if.sv - CPU bus, I/O port and loader signal bundle for moonbase_bus_bridge
interface moonbase_bus_bridge_if #(
    parameter int AW = 7
);
    logic [7:0]    cpu_bus;
    logic [3:0]    cpu_ram;
    logic [1:0]    cpu_data;
    logic          cpu_reset;
    logic [1:0]    port_in;
    logic [3:0]    port_out;
    logic          port_wr;
    logic          load_en;
    logic          load_valid;
    logic [3:0]    load_nibble;
    logic [AW-1:0] load_addr;

    modport slave (
        input  cpu_bus, port_in, load_en, load_valid, load_nibble,
        output cpu_ram, cpu_data, cpu_reset, port_out, port_wr, load_addr
    );

    modport master (
        output cpu_bus, port_in, load_en, load_valid, load_nibble,
        input  cpu_ram, cpu_data, cpu_reset, port_out, port_wr, load_addr
    );
endinterface

// File: rtl/moonbase_bus_bridge.sv
// rtl/moonbase_bus_bridge.sv - address latch, nibble RAM, I/O ports and host loader for the moonbase CPU
module moonbase_bus_bridge #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input logic                 clk,
    input logic                 reset_n,
    moonbase_bus_bridge_if.slave bus
);
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] addr_q;
    logic [AW-1:0] load_addr_q;
    logic [AW-1:0] load_wr_addr;
    logic [3:0]    port_out_q;
    logic          port_wr_q;
    logic          cpu_reset_q;
    logic          load_en_q;
    logic [1:0]    sync_1;
    logic [1:0]    sync_2;
    logic          strobe;
    logic          cpu_cycle;
    logic          ram_we;
    logic          port_we;
    logic          load_we;
    logic          load_rise;
    logic          unused_bits;

    assign unused_bits = ^bus.cpu_bus;

    assign strobe    = bus.cpu_bus[7];
    // load_en blocks CPU writes combinationally, covering the cycle before cpu_reset rises.
    assign cpu_cycle = !cpu_reset_q && !bus.load_en && !strobe;
    assign ram_we    = cpu_cycle && !bus.cpu_bus[5];
    assign port_we   = cpu_cycle && !bus.cpu_bus[4];
    assign load_rise = bus.load_en && !load_en_q;
    assign load_we   = bus.load_en && bus.load_valid;
    // A nibble arriving on the load_en rising edge goes to address 0.
    assign load_wr_addr = load_rise ? '0 : load_addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset_q <= 1'b1;
            load_en_q   <= 1'b0;
            addr_q      <= '0;
            load_addr_q <= '0;
            port_out_q  <= 4'h0;
            port_wr_q   <= 1'b0;
            sync_1      <= 2'b00;
            sync_2      <= 2'b00;
        end else begin
            cpu_reset_q <= bus.load_en;
            load_en_q   <= bus.load_en;
            if (strobe && !cpu_reset_q) begin
                addr_q <= bus.cpu_bus[AW-1:0];
            end
            if (load_we) begin
                load_addr_q <= load_wr_addr + AW'(1);
            end else if (load_rise) begin
                load_addr_q <= '0;
            end
            port_wr_q <= port_we;
            if (port_we) begin
                port_out_q <= bus.cpu_bus[3:0];
            end
            sync_1 <= bus.port_in;
            sync_2 <= sync_1;
        end
    end

    // Storage is deliberately unreset; the loader initialises it.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_wr_addr] <= bus.load_nibble;
        end else if (ram_we) begin
            mem[addr_q] <= bus.cpu_bus[3:0];
        end
    end

    assign bus.cpu_ram   = mem[addr_q];
    assign bus.cpu_data  = sync_2;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.port_out  = port_out_q;
    assign bus.port_wr   = port_wr_q;
    assign bus.load_addr = load_addr_q;
endmodule

// File: tb/tb_moonbase_bus_bridge.sv
// tb/tb_moonbase_bus_bridge.sv - directed plus randomized bench for moonbase_bus_bridge
module tb_moonbase_bus_bridge;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    moonbase_bus_bridge_if #(.AW(7)) bus_if ();

    moonbase_bus_bridge #(.DEPTH(128), .AW(7)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int  m_mem [128];
    bit  m_known [128];
    int  m_addr, m_load_addr, m_port, m_sync1, m_sync2;
    bit  m_port_wr, m_cpu_reset, m_load_prev;
    logic [3:0] wrap_nib [130];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_load_addr = 0; m_port = 0; m_sync1 = 0; m_sync2 = 0;
        m_port_wr = 0; m_cpu_reset = 1; m_load_prev = 0;
    endtask

    task automatic check_all();
        chk("cpu_reset", 8'(bus_if.cpu_reset), 8'(m_cpu_reset));
        chk("port_out",  8'(bus_if.port_out),  8'(m_port));
        chk("port_wr",   8'(bus_if.port_wr),   8'(m_port_wr));
        chk("cpu_data",  8'(bus_if.cpu_data),  8'(m_sync2));
        chk("load_addr", 8'(bus_if.load_addr), 8'(m_load_addr));
        if (m_known[m_addr]) chk("cpu_ram", 8'(bus_if.cpu_ram), 8'(m_mem[m_addr]));
    endtask

    // One clock: apply inputs, advance the reference by the spec's per-edge rules, then compare.
    task automatic step(input logic [7:0] b, input bit le, input bit lv,
                        input logic [3:0] ln, input logic [1:0] pi);
        bit cpu_ok, rise;
        int la;
        bus_if.cpu_bus = b; bus_if.load_en = le; bus_if.load_valid = lv;
        bus_if.load_nibble = ln; bus_if.port_in = pi;
        cpu_ok = !m_cpu_reset && !le && (b[7] == 1'b0);
        rise = le && !m_load_prev;
        if (le && lv) begin
            la = rise ? 0 : m_load_addr;
            m_mem[la] = ln; m_known[la] = 1;
            m_load_addr = (la + 1) % 128;
        end else if (rise) begin
            m_load_addr = 0;
        end
        if (cpu_ok && b[5] == 1'b0) begin
            m_mem[m_addr] = b[3:0]; m_known[m_addr] = 1;
        end
        m_port_wr = cpu_ok && b[4] == 1'b0;
        if (m_port_wr) m_port = b[3:0];
        if (b[7] && !m_cpu_reset) m_addr = b[6:0];
        m_cpu_reset = le;
        m_load_prev = le;
        m_sync2 = m_sync1;
        m_sync1 = pi;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bit le;
        for (int i = 0; i < 128; i++) begin m_known[i] = 0; m_mem[i] = 0; end
        reset_n = 1'b0;
        bus_if.cpu_bus = 8'h00; bus_if.load_en = 1'b0; bus_if.load_valid = 1'b0;
        bus_if.load_nibble = 4'h0; bus_if.port_in = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", 8'(bus_if.cpu_reset), 8'h1);
        chk("rst_port_out",  8'(bus_if.port_out),  8'h0);
        chk("rst_port_wr",   8'(bus_if.port_wr),   8'h0);
        chk("rst_cpu_data",  8'(bus_if.cpu_data),  8'h0);
        chk("rst_load_addr", 8'(bus_if.load_addr), 8'h0);
        reset_n = 1'b1;
        step(8'h30, 0, 0, 4'h0, 2'b00);
        chk("release_cpu_reset", 8'(bus_if.cpu_reset), 8'h0);

        // Load 8,3,F,0,5 with valid low on alternate cycles.
        begin
            logic [3:0] prog [5];
            prog[0] = 4'h8; prog[1] = 4'h3; prog[2] = 4'hF; prog[3] = 4'h0; prog[4] = 4'h5;
            for (int i = 0; i < 10; i++)
                step(8'h00, 1, (i % 2) == 0, (i % 2) == 0 ? prog[i / 2] : 4'h7, 2'b00);
        end
        chk("load5_addr", 8'(bus_if.load_addr), 8'h05);
        chk("load5_cpu_reset", 8'(bus_if.cpu_reset), 8'h1);
        step(8'h30, 0, 0, 4'h0, 2'b00);
        chk("load_drop_cpu_reset", 8'(bus_if.cpu_reset), 8'h0);

        step(8'h84, 0, 0, 4'h0, 2'b00);
        chk("read_mem4", 8'(bus_if.cpu_ram), 8'h05);
        step(8'h30, 0, 0, 4'h0, 2'b00);
        step(8'h80, 0, 0, 4'h0, 2'b00);
        chk("read_mem0", 8'(bus_if.cpu_ram), 8'h08);

        step(8'h92, 0, 0, 4'h0, 2'b00);
        step(8'h1A, 0, 0, 4'h0, 2'b00);
        chk("store_port_wr", 8'(bus_if.port_wr), 8'h0);
        step(8'h92, 0, 0, 4'h0, 2'b00);
        chk("store_readback", 8'(bus_if.cpu_ram), 8'h0A);

        step(8'h80, 0, 0, 4'h0, 2'b00);
        step(8'h2C, 0, 0, 4'h0, 2'b00);
        chk("port_out_c", 8'(bus_if.port_out), 8'h0C);
        chk("port_wr_pulse", 8'(bus_if.port_wr), 8'h1);
        step(8'h30, 0, 0, 4'h0, 2'b10);
        chk("port_wr_single", 8'(bus_if.port_wr), 8'h0);
        chk("mem0_unchanged", 8'(bus_if.cpu_ram), 8'h08);
        chk("cpu_data_1edge", 8'(bus_if.cpu_data), 8'h0);
        step(8'h30, 0, 0, 4'h0, 2'b10);
        chk("cpu_data_2edge", 8'(bus_if.cpu_data), 8'h2);

        // 130 nibbles with a CPU double-write on the bus the whole time; the loader must win.
        for (int i = 0; i < 130; i++) begin
            wrap_nib[i] = 4'($urandom);
            step(8'h00, 1, 1, wrap_nib[i], 2'b00);
        end
        chk("wrap_load_addr", 8'(bus_if.load_addr), 8'h02);
        step(8'h30, 0, 0, 4'h0, 2'b00);
        step(8'h80, 0, 0, 4'h0, 2'b00);
        chk("wrap_mem0", 8'(bus_if.cpu_ram), 8'(wrap_nib[128]));
        step(8'h81, 0, 0, 4'h0, 2'b00);
        chk("wrap_mem1", 8'(bus_if.cpu_ram), 8'(wrap_nib[129]));

        step(8'h92, 0, 0, 4'h0, 2'b00);
        step(8'h1A, 1, 0, 4'h0, 2'b00);
        chk("block_load_addr", 8'(bus_if.load_addr), 8'h00);
        step(8'h30, 0, 0, 4'h0, 2'b00);
        step(8'h92, 0, 0, 4'h0, 2'b00);
        chk("block_mem12", 8'(bus_if.cpu_ram), 8'(wrap_nib[18]));

        le = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) le = !le;
            step(8'($urandom), le, 1'($urandom), 4'($urandom), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
